// File: rtl/psk_mapper_if.sv
// Bit-in / symbol-out bundle of the PSK mapper; the master side is the bit source
// and the slave side is the mapper itself.
interface psk_mapper_if #(
    parameter int unsigned DW = 2
) ();
    logic                 mode;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 bit_ready;
    logic signed [DW-1:0] i_sig;
    logic signed [DW-1:0] q_sig;
    logic                 sym_valid;
    logic                 sym_start;

    modport master (
        output mode, bit_in, bit_valid,
        input  bit_ready, i_sig, q_sig, sym_valid, sym_start
    );

    modport slave (
        input  mode, bit_in, bit_valid,
        output bit_ready, i_sig, q_sig, sym_valid, sym_start
    );
endinterface

// File: rtl/psk_mapper.sv
// psk_mapper: serial bits to BPSK/QPSK I/Q amplitude words, optionally differentially
// encoded, each symbol held for SPS samples with a one-deep pending buffer.
module psk_mapper #(
    parameter int unsigned DW      = 2,
    parameter int unsigned SPS     = 4,
    parameter bit          DIFF_EN = 1'b0
) (
    input logic         clk_sig,
    input logic         rst_n,
    psk_mapper_if.slave bus
);
    localparam int unsigned   CW    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int unsigned   AMP_I = (2 ** (DW - 1)) - 1;
    localparam logic [DW-1:0] POS_A = DW'(AMP_I);
    localparam logic [DW-1:0] NEG_A = ~POS_A + DW'(1);
    localparam logic [CW-1:0] LAST  = CW'(SPS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic i;
        logic q;
        logic bpsk;
    } sym_t;

    function automatic logic [DW-1:0] amp(input logic b);
        return b ? POS_A : NEG_A;
    endfunction

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          half_q, half_n;
    logic          b0_q, b0_n;
    logic          pend_full_q, pend_full_n;
    sym_t          pend_q, pend_n;
    logic          e_q, e_n;
    logic [1:0]    ph_q, ph_n;
    logic [DW-1:0] i_q, i_n;
    logic [DW-1:0] q_q, q_n;
    logic          valid_q, valid_n;
    logic          start_q, start_n;
    logic          ready_q, ready_n;

    logic          out_free;
    logic          complete;
    logic          raw_i;
    logic          raw_q;
    logic          raw_bpsk;
    logic [1:0]    k;
    sym_t          sym_new;

    // Next-state and output logic for both the assembly and hold stages
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        half_n      = half_q;
        b0_n        = b0_q;
        pend_full_n = pend_full_q;
        pend_n      = pend_q;
        e_n         = e_q;
        ph_n        = ph_q;
        i_n         = i_q;
        q_n         = q_q;
        valid_n     = valid_q;
        start_n     = 1'b0;
        complete    = 1'b0;
        raw_i       = 1'b0;
        raw_q       = 1'b0;
        raw_bpsk    = 1'b0;
        k           = 2'b00;
        sym_new     = '0;
        out_free    = (state_q == S_IDLE) || (cnt_q == LAST);

        // A half-assembled dibit forces the QPSK path, so mode only matters on a first bit
        if (bus.bit_valid && ready_q) begin
            if (half_q) begin
                complete = 1'b1;
                raw_i    = b0_q;
                raw_q    = bus.bit_in;
                half_n   = 1'b0;
            end else if (bus.mode) begin
                half_n = 1'b1;
                b0_n   = bus.bit_in;
            end else begin
                complete = 1'b1;
                raw_bpsk = 1'b1;
                raw_i    = bus.bit_in;
            end
        end

        sym_new.i    = raw_i;
        sym_new.q    = raw_q;
        sym_new.bpsk = raw_bpsk;
        if (DIFF_EN && complete) begin
            if (raw_bpsk) begin
                e_n       = e_q ^ raw_i;
                sym_new.i = e_n;
            end else begin
                // dibit increment 00/01/11/10 -> 0/1/2/3; phase 0..3 -> IQ 11/01/00/10
                k         = {raw_i, raw_i ^ raw_q};
                ph_n      = ph_q + k;
                sym_new.i = ~(ph_n[1] ^ ph_n[0]);
                sym_new.q = ~ph_n[1];
            end
        end

        if (out_free) begin
            if (pend_full_q) begin
                i_n         = amp(pend_q.i);
                q_n         = pend_q.bpsk ? '0 : amp(pend_q.q);
                valid_n     = 1'b1;
                start_n     = 1'b1;
                cnt_n       = '0;
                pend_full_n = 1'b0;
                state_n     = S_HOLD;
            end else begin
                i_n     = '0;
                q_n     = '0;
                valid_n = 1'b0;
                state_n = S_IDLE;
            end
        end else begin
            cnt_n = cnt_q + CW'(1);
        end

        if (complete) begin
            pend_full_n = 1'b1;
            pend_n      = sym_new;
        end

        // Registered ready reflects the next cycle's buffer and hold state
        ready_n = !pend_full_n || (state_n == S_IDLE) || (cnt_n == LAST);
    end

    // State and output registers
    always_ff @(posedge clk_sig or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            b0_q        <= 1'b0;
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            e_q         <= 1'b0;
            ph_q        <= 2'b00;
            i_q         <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            start_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            half_q      <= half_n;
            b0_q        <= b0_n;
            pend_full_q <= pend_full_n;
            pend_q      <= pend_n;
            e_q         <= e_n;
            ph_q        <= ph_n;
            i_q         <= i_n;
            q_q         <= q_n;
            valid_q     <= valid_n;
            start_q     <= start_n;
            ready_q     <= ready_n;
        end
    end

    assign bus.bit_ready = ready_q;
    assign bus.i_sig     = i_q;
    assign bus.q_sig     = q_q;
    assign bus.sym_valid = valid_q;
    assign bus.sym_start = start_q;
endmodule

// File: tb/tb_psk_mapper.sv
// Self-checking bench for psk_mapper: absolute and differential instances share one
// bit source; a third SPS=1 instance has its own source.
module tb_psk_mapper;
    localparam int unsigned SPS = 4;
    localparam int unsigned DWA = 4;
    localparam int unsigned DWD = 2;
    localparam int unsigned DWS = 3;

    logic clk_sig = 1'b0;
    logic rst_n;
    always #5 clk_sig = ~clk_sig;

    psk_mapper_if #(.DW(DWA)) if_a ();
    psk_mapper_if #(.DW(DWD)) if_d ();
    psk_mapper_if #(.DW(DWS)) if_s ();

    psk_mapper #(.DW(DWA), .SPS(SPS), .DIFF_EN(1'b0)) u_abs (.clk_sig(clk_sig), .rst_n(rst_n), .bus(if_a));
    psk_mapper #(.DW(DWD), .SPS(SPS), .DIFF_EN(1'b1)) u_dif (.clk_sig(clk_sig), .rst_n(rst_n), .bus(if_d));
    psk_mapper #(.DW(DWS), .SPS(1),   .DIFF_EN(1'b0)) u_s1  (.clk_sig(clk_sig), .rst_n(rst_n), .bus(if_s));

    logic s_mode, s_bit, s_valid;
    logic s1_mode, s1_bit, s1_valid;
    assign if_a.mode = s_mode;  assign if_a.bit_in = s_bit;  assign if_a.bit_valid = s_valid;
    assign if_d.mode = s_mode;  assign if_d.bit_in = s_bit;  assign if_d.bit_valid = s_valid;
    assign if_s.mode = s1_mode; assign if_s.bit_in = s1_bit; assign if_s.bit_valid = s1_valid;

    int n_vec;
    int n_bad;

    // Reference model: bit list -> symbol amplitude lists
    bit bits[$];
    bit modes[$];
    int exp_ai[$], exp_aq[$], exp_di[$], exp_dq[$];
    bit m_e;
    int m_p;
    int kt[4] = '{0, 1, 3, 2};
    bit pi[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit pq[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    function automatic int amp(input int dw, input bit b);
        int a;
        a = (1 << (dw - 1)) - 1;
        return b ? a : -a;
    endfunction

    task automatic build_expected();
        int j;
        bit b0, b1;
        exp_ai.delete(); exp_aq.delete(); exp_di.delete(); exp_dq.delete();
        j = 0;
        while (j < bits.size()) begin
            if (modes[j] == 1'b0) begin
                b0 = bits[j];
                j++;
                m_e = m_e ^ b0;
                exp_ai.push_back(amp(DWA, b0));  exp_aq.push_back(0);
                exp_di.push_back(amp(DWD, m_e)); exp_dq.push_back(0);
            end else begin
                b0 = bits[j];
                b1 = bits[j+1];
                j += 2;
                m_p = (m_p + kt[{b0, b1}]) % 4;
                exp_ai.push_back(amp(DWA, b0));        exp_aq.push_back(amp(DWA, b1));
                exp_di.push_back(amp(DWD, pi[m_p]));   exp_dq.push_back(amp(DWD, pq[m_p]));
            end
        end
    endtask

    task automatic gen_random(input int nbits, input int qpsk_pct);
        bit m;
        bits.delete(); modes.delete();
        while (bits.size() < nbits) begin
            m = ($urandom_range(99) < qpsk_pct);
            bits.push_back(1'($urandom)); modes.push_back(m);
            if (m) begin
                bits.push_back(1'($urandom)); modes.push_back(1'($urandom));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s1_valid = 1'b0;
        repeat (2) @(negedge clk_sig);
        n_vec++;
        if ({if_a.sym_valid, if_a.sym_start, if_a.i_sig, if_a.q_sig, if_d.sym_valid, if_d.i_sig, if_d.q_sig,
             if_s.sym_valid, if_s.i_sig, if_a.bit_ready, if_d.bit_ready, if_s.bit_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: a v=%b i=%0d q=%0d rdy=%b, d v=%b rdy=%b, s v=%b rdy=%b; need all 0",
                     if_a.sym_valid, if_a.i_sig, if_a.q_sig, if_a.bit_ready, if_d.sym_valid, if_d.bit_ready,
                     if_s.sym_valid, if_s.bit_ready);
        end
        rst_n = 1'b1;
        m_e = 1'b0; m_p = 0;
        #1;
        n_vec++;
        if (if_a.bit_ready !== 1'b0) begin
            n_bad++; $display("FAIL ready_at_release: got %b need 0", if_a.bit_ready);
        end
        @(negedge clk_sig);
        n_vec++;
        if ({if_a.bit_ready, if_d.bit_ready, if_s.bit_ready, if_a.sym_valid} !== 4'b1110) begin
            n_bad++;
            $display("FAIL ready_after_release: got rdy=%b%b%b v=%b need rdy=111 v=0",
                     if_a.bit_ready, if_d.bit_ready, if_s.bit_ready, if_a.sym_valid);
        end
    endtask

    // Streams bits/modes through both 4-SPS instances and checks every output sample
    task automatic test_stream(input int stall_pct, input string tag);
        int total, popped, hold, cyc, bound;
        bit active;
        int cai, caq, cdi, cdq;
        logic signed [31:0] ai, aq, di, dq;
        build_expected();
        total = exp_ai.size();
        bound = 20 * bits.size() + 50;
        fork
            begin : drv
                int idx;
                idx = 0;
                while (idx < bits.size()) begin
                    @(negedge clk_sig);
                    if ($urandom_range(99) < stall_pct) s_valid = 1'b0;
                    else begin
                        s_valid = 1'b1; s_bit = bits[idx]; s_mode = modes[idx];
                        if (if_a.bit_ready) idx++;
                    end
                end
                @(negedge clk_sig);
                s_valid = 1'b0;
            end
            begin : chk
                popped = 0; hold = 0; cyc = 0; active = 1'b0;
                cai = 0; caq = 0; cdi = 0; cdq = 0;
                while (!(popped == total && !active) && cyc < bound) begin
                    @(negedge clk_sig);
                    cyc++;
                    ai = if_a.i_sig; aq = if_a.q_sig; di = if_d.i_sig; dq = if_d.q_sig;
                    if (if_a.sym_start === 1'b1) begin
                        n_vec++;
                        if ((active && hold != SPS) || popped >= total) begin
                            n_bad++;
                            $display("FAIL %s unexpected_start: hold=%0d popped=%0d of %0d", tag, hold, popped, total);
                        end
                        if (popped < total) begin
                            cai = exp_ai.pop_front(); caq = exp_aq.pop_front();
                            cdi = exp_di.pop_front(); cdq = exp_dq.pop_front();
                            popped++;
                        end
                        n_vec++;
                        if ({ai, aq, di, dq} !== {32'(cai), 32'(caq), 32'(cdi), 32'(cdq)} ||
                            {if_a.sym_valid, if_d.sym_valid, if_d.sym_start} !== 3'b111) begin
                            n_bad++;
                            $display("FAIL %s symbol[%0d]: got a=(%0d,%0d) d=(%0d,%0d) v=%b%b ds=%b need a=(%0d,%0d) d=(%0d,%0d) v=11 ds=1",
                                     tag, popped, ai, aq, di, dq, if_a.sym_valid, if_d.sym_valid, if_d.sym_start,
                                     cai, caq, cdi, cdq);
                        end
                        active = 1'b1; hold = 1;
                    end else if (active && hold < SPS) begin
                        n_vec++;
                        if ({ai, aq, di, dq} !== {32'(cai), 32'(caq), 32'(cdi), 32'(cdq)} ||
                            {if_a.sym_valid, if_d.sym_valid, if_d.sym_start} !== 3'b110) begin
                            n_bad++;
                            $display("FAIL %s hold[%0d] cyc %0d: got a=(%0d,%0d) d=(%0d,%0d) v=%b%b ds=%b need a=(%0d,%0d) d=(%0d,%0d) v=11 ds=0",
                                     tag, popped, hold, ai, aq, di, dq, if_a.sym_valid, if_d.sym_valid, if_d.sym_start,
                                     cai, caq, cdi, cdq);
                        end
                        hold++;
                    end else begin
                        if (active && stall_pct == 0 && popped < total) begin
                            n_vec++; n_bad++;
                            $display("FAIL %s gap: no sym_start after %0d held samples, popped %0d of %0d",
                                     tag, hold, popped, total);
                        end
                        n_vec++;
                        if ({ai, aq, di, dq} !== '0 || {if_a.sym_valid, if_d.sym_valid, if_d.sym_start} !== 3'b000) begin
                            n_bad++;
                            $display("FAIL %s idle: got a=(%0d,%0d) d=(%0d,%0d) v=%b%b ds=%b need zeros",
                                     tag, ai, aq, di, dq, if_a.sym_valid, if_d.sym_valid, if_d.sym_start);
                        end
                        active = 1'b0;
                    end
                end
                if (cyc >= bound) begin
                    n_vec++; n_bad++;
                    $display("FAIL %s timeout: got %0d symbols need %0d", tag, popped, total);
                end
            end
        join
    endtask

    task automatic test_stall();
        logic signed [31:0] ai, di, aq;
        int ea, ed;
        s_mode = 1'b0;
        @(negedge clk_sig);
        s_valid = 1'b1; s_bit = 1'b1;
        @(negedge clk_sig);
        s_valid = 1'b0;
        n_vec++;
        if (if_a.sym_valid !== 1'b0) begin
            n_bad++; $display("FAIL stall_latency_early: got v=%b need 0", if_a.sym_valid);
        end
        m_e = m_e ^ 1'b1;
        ea = amp(DWA, 1'b1); ed = amp(DWD, m_e);
        for (int c = 0; c < SPS; c++) begin
            @(negedge clk_sig);
            ai = if_a.i_sig; di = if_d.i_sig;
            n_vec++;
            if ({if_a.sym_valid, if_a.sym_start, ai, di, if_a.bit_ready} !== {1'b1, 1'(c == 0), 32'(ea), 32'(ed), 1'b1}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got v=%b s=%b a=%0d d=%0d rdy=%b need v=1 s=%b a=%0d d=%0d rdy=1",
                         c, if_a.sym_valid, if_a.sym_start, ai, di, if_a.bit_ready, c == 0, ea, ed);
            end
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_sig);
            ai = if_a.i_sig; aq = if_a.q_sig; di = if_d.i_sig;
            n_vec++;
            if ({if_a.sym_valid, if_a.sym_start, ai, aq, di, if_a.bit_ready} !== {2'b00, 96'd0, 1'b1}) begin
                n_bad++;
                $display("FAIL stall_idle[%0d]: got v=%b s=%b a=(%0d,%0d) d=%0d rdy=%b need v=0 s=0 zeros rdy=1",
                         c, if_a.sym_valid, if_a.sym_start, ai, aq, di, if_a.bit_ready);
            end
        end
        s_valid = 1'b1; s_bit = 1'b0;
        @(negedge clk_sig);
        s_valid = 1'b0;
        @(negedge clk_sig);
        ai = if_a.i_sig; di = if_d.i_sig;
        ea = amp(DWA, 1'b0); ed = amp(DWD, m_e);
        n_vec++;
        if ({if_a.sym_start, if_a.sym_valid, ai, di} !== {2'b11, 32'(ea), 32'(ed)}) begin
            n_bad++;
            $display("FAIL stall_restart: got s=%b v=%b a=%0d d=%0d need s=1 v=1 a=%0d d=%0d",
                     if_a.sym_start, if_a.sym_valid, ai, di, ea, ed);
        end
        repeat (SPS) @(negedge clk_sig);
    endtask

    task automatic test_reset_mid();
        int acc, g;
        s_mode = 1'b0; s_bit = 1'b1; s_valid = 1'b1;
        acc = 0; g = 0;
        while (acc < 2 && g < 50) begin
            if (if_a.bit_ready) acc++;
            @(negedge clk_sig);
            g++;
        end
        s_valid = 1'b0;
        @(negedge clk_sig);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({if_a.sym_valid, if_a.sym_start, if_a.i_sig, if_a.q_sig, if_d.sym_valid, if_d.i_sig, if_a.bit_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_hold: got a v=%b s=%b i=%0d q=%0d rdy=%b, d v=%b i=%0d need all 0",
                     if_a.sym_valid, if_a.sym_start, if_a.i_sig, if_a.q_sig, if_a.bit_ready, if_d.sym_valid, if_d.i_sig);
        end
        @(negedge clk_sig);
        rst_n = 1'b1;
        m_e = 1'b0; m_p = 0;
        @(negedge clk_sig);
        bits = '{1'b0, 1'b1}; modes = '{1'b1, 1'b1};
        test_stream(0, "post_reset_qpsk");
    endtask

    task automatic test_sps1();
        bit hist[$];
        logic signed [31:0] si, sq;
        int ei;
        bit on;
        for (int t = 0; t < 24; t++) begin
            si = if_s.i_sig; sq = if_s.q_sig;
            on = (t >= 2) && (t < 22);
            ei = 0;
            if (on) ei = amp(DWS, hist[t-2]);
            n_vec++;
            if ({if_s.sym_valid, if_s.sym_start, si, sq} !== {on, on, 32'(ei), 32'd0}) begin
                n_bad++;
                $display("FAIL sps1[%0d]: got v=%b s=%b i=%0d q=%0d need v=%b s=%b i=%0d q=0",
                         t, if_s.sym_valid, if_s.sym_start, si, sq, on, on, ei);
            end
            if (t < 20) begin
                n_vec++;
                if (if_s.bit_ready !== 1'b1) begin
                    n_bad++; $display("FAIL sps1_ready[%0d]: got %b need 1", t, if_s.bit_ready);
                end
                s1_valid = 1'b1; s1_mode = 1'b0; s1_bit = 1'($urandom);
                hist.push_back(s1_bit);
            end else begin
                s1_valid = 1'b0;
            end
            @(negedge clk_sig);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        rst_n = 1'b0;
        s_mode = 1'b0; s_bit = 1'b0; s_valid = 1'b0;
        s1_mode = 1'b0; s1_bit = 1'b0; s1_valid = 1'b0;
        m_e = 1'b0; m_p = 0;

        test_reset();
        bits = '{1'b1, 1'b1, 1'b0}; modes = '{1'b0, 1'b0, 1'b0};
        test_stream(0, "diff_bpsk_110");
        bits = '{1'b1, 1'b0}; modes = '{1'b0, 1'b0};
        test_stream(0, "bpsk_10");
        bits = '{1'b1, 1'b0, 1'b0, 1'b1}; modes = '{1'b1, 1'b1, 1'b1, 1'b1};
        test_stream(0, "qpsk_10_01");
        bits = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; modes = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        test_stream(0, "diff_qpsk_01_11_10");
        test_stall();
        gen_random(40, 0);   test_stream(0, "rand_bpsk");
        gen_random(40, 100); test_stream(0, "rand_qpsk");
        gen_random(60, 50);  test_stream(30, "rand_mixed_stall");
        test_reset_mid();
        test_sps1();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/psk_mapper.md
Name: psk_mapper

Overview:
- Parametrised successor of the single-bit BPSK mapper.
- Accepts a serial bit stream over a valid/ready handshake.
- Groups bits into BPSK (1 bit) or QPSK (2 bits) symbols, with optional differential encoding.
- Drives signed I/Q amplitude words, each symbol held for SPS clock cycles. Sits between the base-band bit source and the DAC/shaping-filter stage.

Parameters:
- DW, 2, I/Q word width (two's complement, >=2); amplitude A = 2^(DW-1)-1.
- SPS, 4, samples (clock cycles) each symbol is held on the output (>=1).
- DIFF_EN, 0, 1 = differential encoding enabled, 0 = absolute mapping.

Ports:
- clk_sig  in  1  sample clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = BPSK, 1 = QPSK; sampled when the first bit of a symbol is accepted.
- bit_in  in  1  serial data bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  mapper accepts a bit this cycle; a transfer occurs on bit_valid && bit_ready.
- i_sig  out  DW  in-phase amplitude, signed.
- q_sig  out  DW  quadrature amplitude, signed.
- sym_valid  out  1  i_sig/q_sig carry a symbol.
- sym_start  out  1  one-cycle pulse on the first sample of each symbol.

Behaviour:
- Reset (async, rst_n=0):
  - i_sig = q_sig = 0; sym_valid = 0; sym_start = 0.
  - Assembly register, pending register, hold counter and differential phase all cleared.
  - bit_ready = 1 one cycle after release.
- Amplitude mapping: bit 1 -> +A; bit 0 -> -A. DW=2 gives 2'b01 and 2'b11.
- Stage 1, assembly:
  - BPSK: a symbol completes on every accepted bit.
  - QPSK: the first accepted bit is b0 (I), the second is b1 (Q).
  - Mode is latched on the first bit of a symbol. A mode change while a QPSK symbol is half-assembled takes effect only from the next symbol.
  - The completed symbol is written to the pending register on the accepting edge.
- Stage 2, output/hold:
  - States: IDLE, HOLD.
  - The output is "free" when in IDLE, or when in HOLD with the hold counter = SPS-1.
  - If free and pending is full: load the symbol into i_sig/q_sig, set sym_valid=1 and sym_start=1, clear the counter, clear pending, enter or stay in HOLD.
  - If free and pending is empty: i_sig = q_sig = 0, sym_valid = 0, go to IDLE.
  - Otherwise: increment the counter; sym_start = 0.
- bit_ready = !pending_full || (pending_full && output free). Back-to-back symbols therefore stream with no gap whenever the source keeps up.
- Latency: the symbol appears on the edge after the completing bit is accepted, if the output is idle.
- BPSK output: q_sig = 0 at all times.
- Absolute QPSK: i_sig = map(b0), q_sig = map(b1).
- Differential, DIFF_EN=1:
  - BPSK: encoded bit e = e_prev XOR b, with e_prev = 0 after reset; output map(e).
  - QPSK: the dibit {b0,b1} gives increment k (00->0, 01->1, 11->2, 10->3). Phase p = (p+k) mod 4, with p = 0 after reset. Phase-to-(I,Q) bits: 0 -> (1,1), 1 -> (0,1), 2 -> (0,0), 3 -> (1,0).
  - The differential state updates when the symbol enters pending.
  - The differential state is shared across modes and is not reset on a mode change.
- SPS=1: the counter is always at SPS-1, so every cycle is free; one symbol per cycle.
- Reset mid-symbol: the partial symbol, the pending symbol and the current output are discarded immediately; no sym_start is issued for the discarded data.

Test Plan:
- DW=2, SPS=4, BPSK, bits 1,0 streamed continuously -> i_sig = 01 for 4 cycles then 11 for 4; q_sig = 00; sym_start at cycles 0 and 4; no gap.
- DW=4, QPSK, dibits (1,0) then (0,1) -> (i,q) = (+7,-7) then (-7,+7), each held 4 cycles.
- DIFF_EN=1, BPSK, bits 1,1,0 -> encoded bits 1,0,0 -> i_sig = +A, -A, -A.
- DIFF_EN=1, QPSK, dibits 01, 11, 10 -> phase 1, 3, 2 -> (I,Q) bits (0,1), (1,0), (0,0).
- Source stalls after one symbol -> after 4 held cycles, sym_valid=0 and i_sig = q_sig = 0; bit_ready stays 1; the next bit restarts output with sym_start.
- rst_n pulled low mid-hold with pending full -> all outputs 0 asynchronously; after release, the first new bit produces a fresh symbol and differential state starts from 0.
